mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Load/store controller that sits between the CPU datapath and the word-organised `ram` block and acts as the initiator on its `cs`/`rd`/`oe` interface. It accepts one byte, halfword or word request at a time and translates it into RAM cycles. Sub-word stores use a read-modify-write sequence because the RAM only writes whole words. Sub-word loads return zero- or sign-extended data, and misaligned or out-of-range accesses complete with an error flag and never reach the RAM.

## Interface
- No parameters. Memory is fixed at 256 words (1 KiB, byte addresses 0x000–0x3FF). Lanes are little-endian: byte at addr[1:0]=0 is bits 7:0.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word; 11 is an error.
- `req_sign`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  valid with resp_valid: misaligned, out-of-range or bad size.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `ram_addr`  out  8  word address = addr[9:2].
- `ram_cs`, `ram_rd`, `ram_oe`  out  1 each  RAM controls.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data; valid while cs&rd&oe.

## Operation
- States: IDLE, READ, WRITE, RMW_READ, RMW_WRITE, RESP.
- IDLE, when req_valid is high at a posedge:
  - Latch all req_* fields.
  - Error check. Any of the following sends the controller to RESP with err=1: req_size==11; half with addr[0]=1; word with addr[1:0]≠0; addr[31:10]≠0.
  - Otherwise route by request type: load → READ; word store → WRITE; byte or half store → RMW_READ.
- READ: drive cs=1, rd=1, oe=1, ram_addr. At the next edge, capture ram_rdata, select the lane by addr[1:0], extend it, and go to RESP.
- WRITE: drive cs=1, rd=0, oe=0, ram_wdata=req_wdata. The RAM commits at the negedge inside this cycle. Go to RESP.
- RMW_READ: same as READ. Capture the full word into the merge register, then go to RMW_WRITE.
- RMW_WRITE: drive cs=1, rd=0. ram_wdata is the captured word with the addressed byte or half lane replaced by req_wdata[7:0] or [15:0]. Go to RESP.
- RESP: resp_valid=1 with resp_err and resp_rdata, then return to IDLE.
- resp_err and resp_rdata hold their values until the next RESP.
- Outside READ, WRITE, RMW_READ and RMW_WRITE: cs=rd=oe=0.
- All ram_* outputs and req_ready are decoded from registered state and latched fields only. There is no combinational path from req_* or ram_rdata to any output.

## Timing
- Reset values (rst sampled high at a posedge):
  - State returns to IDLE; the latched request and merge register are discarded.
  - ram_cs=ram_rd=ram_oe=0, ram_addr=0, ram_wdata=0.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - req_ready is held 0 while rst is high.
- Request accepted at edge k. resp_valid is high in the cycle after:
  - edge k+1 for errors;
  - edge k+2 for loads and word stores;
  - edge k+3 for sub-word stores.
- Throughput: the next request can be accepted at the edge that ends RESP. For a word load with req_valid held, acceptances are 3 cycles apart.
- req_* fields need only be stable at the accepting edge.
- Reset mid-operation:
  - A WRITE or RMW_WRITE cycle already being driven when rst is sampled still commits at that cycle's negedge.
  - Reset during READ or RMW_READ causes no RAM write.
  - No response is issued for the abandoned request.

## Test plan
- Word store 0xDEADBEEF to addr 0x010, then word load from 0x010. Required: ram_cs high in exactly one cycle with rd=0 and ram_addr=0x04; the load returns 0xDEADBEEF with resp_valid at k+2.
- Byte store 0xAB to addr 0x011 after the above. Required: RMW_READ then RMW_WRITE with ram_wdata=0xDEADABEF; resp at k+3.
- Byte loads from addr 0x011:
  - signed load returns 0xFFFFFFAB;
  - unsigned load returns 0x000000AB.
- Half store 0x8001 to addr 0x012, then half loads from 0x012:
  - the word becomes 0x8001ABEF;
  - signed load returns 0xFFFF8001; unsigned load returns 0x00008001.
- Error cases: word load at 0x013, half load at 0x011, word load at 0x400, and size=11. Required for each: resp_err=1 at k+1, resp_rdata=0, and ram_cs never asserted.
- Assert rst during RMW_READ of a byte store to 0x010. Required: no resp_valid, the word is unchanged, all outputs take their reset values, and req_ready=1 one cycle after rst drops.

Source files
------------

// File: rtl/mem_ctrl.sv
// Load/store controller bridging byte/half/word CPU requests onto a word-wide RAM.
// Sub-word stores use read-modify-write. Bad accesses finish with an error and never reach the RAM.
module mem_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sign_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] resp_rdata_o,
  output logic [7:0]  ram_addr_o,
  output logic        ram_cs_o,
  output logic        ram_rd_o,
  output logic        ram_oe_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  localparam int unsigned DW  = 32;
  localparam int unsigned RAW = 8;
  localparam int unsigned HW  = 16;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ      = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_RMW_READ  = 3'd3;
  localparam logic [2:0] S_RMW_WRITE = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  logic [2:0]     state_q, state_d;
  logic [1:0]     size_q, size_d;
  logic           sign_q, sign_d;
  logic [1:0]     off_q, off_d;
  logic [HW-1:0]  wdata_q, wdata_d;
  logic           err_q, err_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [RAW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0]  ram_wdata_q, ram_wdata_d;
  logic           ram_cs_q, ram_cs_d;
  logic           ram_rd_q, ram_rd_d;
  logic           ram_oe_q, ram_oe_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_err_q, resp_err_d;
  logic [DW-1:0]  resp_rdata_q, resp_rdata_d;
  logic           ready_q, ready_d;

  logic           accept;
  logic           bad_req;

  // Pick the addressed lane out of a RAM word and zero/sign-extend it
  function automatic logic [DW-1:0] load_ext(input logic [DW-1:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic sign);
    logic [7:0]    b;
    logic [HW-1:0] h;
    logic [DW-1:0] r;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      SZ_BYTE: r = sign ? {{24{b[7]}}, b} : {24'h0, b};
      SZ_HALF: r = sign ? {{16{h[15]}}, h} : {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte or half lane of a RAM word with store data
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] w, input logic [1:0] off,
                                          input logic [1:0] size, input logic [HW-1:0] d);
    logic [DW-1:0] m;
    m = w;
    if (size == SZ_BYTE) begin
      case (off)
        2'd0:    m[7:0]   = d[7:0];
        2'd1:    m[15:8]  = d[7:0];
        2'd2:    m[23:16] = d[7:0];
        default: m[31:24] = d[7:0];
      endcase
    end else if (off[1]) begin
      m[31:16] = d;
    end else begin
      m[15:0] = d;
    end
    return m;
  endfunction

  // Request acceptance and access legality check
  always_comb begin
    accept  = ready_q & req_valid_i;
    bad_req = (req_size_i == SZ_BAD)
            | ((req_size_i == SZ_HALF) & req_addr_i[0])
            | ((req_size_i == SZ_WORD) & (|req_addr_i[1:0]))
            | (|req_addr_i[31:10]);
  end

  // State register and all registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      size_q       <= '0;
      sign_q       <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_cs_q     <= 1'b0;
      ram_rd_q     <= 1'b0;
      ram_oe_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_cs_q     <= ram_cs_d;
      ram_rd_q     <= ram_rd_d;
      ram_oe_q     <= ram_oe_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    sign_d       = sign_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          size_d  = req_size_i;
          sign_d  = req_sign_i;
          off_d   = req_addr_i[1:0];
          wdata_d = req_wdata_i[HW-1:0];
          err_d   = bad_req;
          rdata_d = '0;
          if (bad_req) begin
            state_d = S_RESP;
          end else begin
            ram_addr_d = req_addr_i[9:2];
            if (!req_we_i) begin
              state_d = S_READ;
            end else if (req_size_i == SZ_WORD) begin
              state_d     = S_WRITE;
              ram_wdata_d = req_wdata_i;
            end else begin
              state_d = S_RMW_READ;
            end
          end
        end
      end
      S_READ: begin
        rdata_d = load_ext(ram_rdata_i, off_q, size_q, sign_q);
        state_d = S_RESP;
      end
      S_WRITE: begin
        state_d = S_RESP;
      end
      S_RMW_READ: begin
        ram_wdata_d = merge(ram_rdata_i, off_q, size_q, wdata_q);
        state_d     = S_RMW_WRITE;
      end
      S_RMW_WRITE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        resp_rdata_d = rdata_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // RAM strobes follow the state being entered so they line up with it once registered
    ram_cs_d = (state_d == S_READ) | (state_d == S_WRITE)
             | (state_d == S_RMW_READ) | (state_d == S_RMW_WRITE);
    ram_rd_d = (state_d == S_READ) | (state_d == S_RMW_READ);
    ram_oe_d = ram_rd_d;
    ready_d  = (state_d == S_IDLE);
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_cs_o     = ram_cs_q;
  assign ram_rd_o     = ram_rd_q;
  assign ram_oe_o     = ram_oe_q;
  assign ram_wdata_o  = ram_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table with scoreboard, plus throughput and reset sequences.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  ram_addr;
  logic        ram_cs;
  logic        ram_rd;
  logic        ram_oe;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_sign_i(req_sign), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_err_o(resp_err), .resp_rdata_o(resp_rdata),
    .ram_addr_o(ram_addr), .ram_cs_o(ram_cs), .ram_rd_o(ram_rd), .ram_oe_o(ram_oe),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Word RAM model: writes commit at the negedge of a cs & !rd cycle
  logic [31:0] mem [256];
  always @(negedge clk) if (ram_cs && !ram_rd) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = (ram_cs && ram_rd && ram_oe) ? mem[ram_addr] : 32'h0;

  // RAM activity monitor
  int          cs_total = 0;
  int          wr_total = 0;
  logic [31:0] wr_data_last = '0;
  logic [7:0]  wr_addr_last = '0;
  always @(negedge clk) begin
    if (ram_cs) cs_total = cs_total + 1;
    if (ram_cs && !ram_rd) begin
      wr_total     = wr_total + 1;
      wr_data_last = ram_wdata;
      wr_addr_last = ram_addr;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          cs;
    int          wr;
    logic [31:0] wword;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  exp_t sb [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sign,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata, input int lat,
                              input int cs, input int wr, input logic [31:0] wword);
    vec_t v;
    v.we = we; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.lat = lat; v.cs = cs; v.wr = wr; v.wword = wword;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard = guard + 1;
    end
    chk({name, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cs0;
    int   wr0;
    int   lat;
    logic got;
    exp_t e;
    string nm;
    nm = $sformatf("v%0d", idx);
    wait_ready(nm);
    req_we = v.we; req_size = v.size; req_sign = v.sign;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    e.err = v.err; e.rdata = v.rdata; e.lat = v.lat;
    sb.push_back(e);
    cs0 = cs_total;
    wr0 = wr_total;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_lat"}, 32'(lat), 32'(e.lat));
      chk({nm, "_err"}, 32'(resp_err), 32'(e.err));
      chk({nm, "_rdata"}, resp_rdata, e.rdata);
      @(posedge clk);
      #1;
      chk({nm, "_pulse"}, 32'(resp_valid), 32'd0);
      chk({nm, "_hold"}, resp_rdata, e.rdata);
    end
    chk({nm, "_cs_cycles"}, 32'(cs_total - cs0), 32'(v.cs));
    chk({nm, "_wr_cycles"}, 32'(wr_total - wr0), 32'(v.wr));
    if (v.wr != 0) begin
      chk({nm, "_wdata"}, wr_data_last, v.wword);
      chk({nm, "_waddr"}, 32'(wr_addr_last), 32'(v.addr[9:2]));
    end
  endtask

  initial begin
    int          acc_idx [$];
    logic        seen;
    int          wr0;
    logic [31:0] last_rd;

    vecs[0]  = mk(1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 0, 32'h0,        2, 1, 1, 32'hDEADBEEF);
    vecs[1]  = mk(0, 2'b10, 0, 32'h010, 32'h0,        0, 32'hDEADBEEF, 2, 1, 0, 32'h0);
    vecs[2]  = mk(1, 2'b00, 0, 32'h011, 32'h000000AB, 0, 32'h0,        3, 2, 1, 32'hDEADABEF);
    vecs[3]  = mk(0, 2'b00, 1, 32'h011, 32'h0,        0, 32'hFFFFFFAB, 2, 1, 0, 32'h0);
    vecs[4]  = mk(0, 2'b00, 0, 32'h011, 32'h0,        0, 32'h000000AB, 2, 1, 0, 32'h0);
    vecs[5]  = mk(1, 2'b01, 0, 32'h012, 32'h00008001, 0, 32'h0,        3, 2, 1, 32'h8001ABEF);
    vecs[6]  = mk(0, 2'b01, 1, 32'h012, 32'h0,        0, 32'hFFFF8001, 2, 1, 0, 32'h0);
    vecs[7]  = mk(0, 2'b01, 0, 32'h012, 32'h0,        0, 32'h00008001, 2, 1, 0, 32'h0);
    vecs[8]  = mk(0, 2'b10, 0, 32'h010, 32'h0,        0, 32'h8001ABEF, 2, 1, 0, 32'h0);
    vecs[9]  = mk(0, 2'b10, 0, 32'h013, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0);
    vecs[10] = mk(0, 2'b01, 0, 32'h011, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0);
    vecs[11] = mk(0, 2'b10, 0, 32'h400, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0);
    vecs[12] = mk(0, 2'b11, 0, 32'h010, 32'h0,        1, 32'h0,        1, 0, 0, 32'h0);
    vecs[13] = mk(1, 2'b00, 0, 32'h013, 32'hFFFFFF7E, 0, 32'h0,        3, 2, 1, 32'h7E01ABEF);
    vecs[14] = mk(0, 2'b00, 1, 32'h013, 32'h0,        0, 32'h0000007E, 2, 1, 0, 32'h0);
    vecs[15] = mk(1, 2'b01, 0, 32'h010, 32'h12345678, 0, 32'h0,        3, 2, 1, 32'h7E015678);
    vecs[16] = mk(0, 2'b10, 0, 32'h010, 32'h0,        0, 32'h7E015678, 2, 1, 0, 32'h0);
    vecs[17] = mk(1, 2'b10, 0, 32'h402, 32'h11111111, 1, 32'h0,        1, 0, 0, 32'h0);

    // Reset state
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_sign = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_ctl", {29'd0, ram_cs, ram_rd, ram_oe}, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Throughput: word load with req_valid held
    wait_ready("thr");
    req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0; req_addr = 32'h010; req_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) acc_idx.push_back(i);
    end
    req_valid = 1'b0;
    if (acc_idx.size() >= 2) chk("thr_spacing", 32'(acc_idx[1] - acc_idx[0]), 32'd3);
    else chk("thr_accepts", 32'(acc_idx.size()), 32'd2);
    repeat (4) @(negedge clk);
    chk("thr_rdata", resp_rdata, 32'h7E015678);

    // Reset during RMW_READ of a byte store to 0x010
    wait_ready("rstmid");
    req_we = 1'b1; req_size = 2'b00; req_sign = 1'b0; req_addr = 32'h010;
    req_wdata = 32'h00000055; req_valid = 1'b1;
    wr0 = wr_total;
    seen = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_rmw_read", {29'd0, ram_cs, ram_rd, ram_oe}, 32'd7);
    rst = 1'b1;
    @(negedge clk);
    if (resp_valid) seen = 1'b1;
    chk("rstmid_ready", 32'(req_ready), 32'd0);
    chk("rstmid_ram_ctl", {29'd0, ram_cs, ram_rd, ram_oe}, 32'd0);
    chk("rstmid_ram_addr", 32'(ram_addr), 32'd0);
    chk("rstmid_ram_wdata", ram_wdata, 32'd0);
    chk("rstmid_resp", {30'd0, resp_err, resp_valid}, 32'd0);
    chk("rstmid_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    if (resp_valid) seen = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    if (resp_valid) seen = 1'b1;
    chk("rstmid_ready_after", 32'(req_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("rstmid_no_resp", 32'(seen), 32'd0);
    chk("rstmid_no_write", 32'(wr_total - wr0), 32'd0);
    last_rd = mem[4];
    chk("rstmid_word", last_rd, 32'h7E015678);
    run_vec(vecs[16], 99);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
